// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest commit-side monitors: trap codes,
// commit width and the trap-detector state encoding.
package difftest_pkg;

    localparam int unsigned COMMIT_WIDTH = 2;

    localparam logic [2:0] TRAP_GOOD  = 3'd0;
    localparam logic [2:0] TRAP_BAD   = 3'd1;
    localparam logic [2:0] TRAP_ABORT = 3'd2;
    localparam logic [2:0] TRAP_LIMIT = 3'd3;

    typedef enum logic {
        RUN,
        TRAPPED
    } state_e;

    // A trap instruction reports success only when a0 is zero.
    function automatic logic [2:0] trap_code(input logic [63:0] arg);
        return (arg == 64'd0) ? TRAP_GOOD : TRAP_BAD;
    endfunction

    function automatic logic [1:0] retire_count(input logic [COMMIT_WIDTH-1:0] valid);
        return {1'b0, valid[0]} + {1'b0, valid[1]};
    endfunction

endpackage

// File: rtl/difftest_watchdog.sv
// Saturating idle-cycle counter: cleared by any commit, advances while enabled,
// and flags the cycle in which it reaches the timeout value.
module difftest_watchdog #(
    parameter int unsigned Timeout = 5000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [31:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc = (cnt_q == Timeout) ? cnt_q : cnt_q + 32'd1;
        cnt_d   = cnt_q;
        if (en_i) begin
            cnt_d = clr_i ? 32'd0 : cnt_inc;
        end
        // A zero timeout disables the watchdog entirely.
        timeout_o = en_i && !clr_i && (Timeout != 0) && (cnt_inc == Timeout);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/difftest_trap_detect.sv
// Commit-side trap monitor: counts cycles and retirements, detects trap,
// limit and watchdog events, then holds the terminating record until reset.
module difftest_trap_detect
    import difftest_pkg::*;
#(
    parameter logic [7:0]      COREID    = 8'd0,
    parameter int unsigned     TIMEOUT   = 5000,
    parameter longint unsigned MAX_INSTR = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [COMMIT_WIDTH-1:0]   io_commit_valid,
    input  logic [COMMIT_WIDTH-1:0]   io_commit_isTrap,
    input  logic [64*COMMIT_WIDTH-1:0] io_commit_pc,
    input  logic [63:0]               io_trapArg,
    output logic [7:0]                io_coreid,
    output logic                      io_valid,
    output logic [63:0]               io_cycleCnt,
    output logic [63:0]               io_instrCnt,
    output logic [2:0]                io_code,
    output logic [63:0]               io_pc
);

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instr_q, instr_d;
    logic [2:0]  code_q, code_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] last_pc_q, last_pc_d;

    logic [63:0]             pc0, pc1, instr_inc;
    logic                    trap0, trap1, running, any_commit, limit_hit, wd_timeout;
    logic [COMMIT_WIDTH-1:0] eff_valid;

    assign pc0 = io_commit_pc[63:0];
    assign pc1 = io_commit_pc[127:64];

    assign trap0      = io_commit_valid[0] & io_commit_isTrap[0];
    assign trap1      = io_commit_valid[1] & io_commit_isTrap[1];
    // Nothing younger than a slot-0 trap retires.
    assign eff_valid  = {io_commit_valid[1] & ~trap0, io_commit_valid[0]};
    assign instr_inc  = instr_q + {62'd0, retire_count(eff_valid)};
    assign running    = (state_q == RUN);
    assign any_commit = |io_commit_valid;
    assign limit_hit  = (MAX_INSTR != 64'd0) && (instr_inc >= MAX_INSTR);

    difftest_watchdog #(
        .Timeout (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clr_i     (any_commit),
        .en_i      (running),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        cycle_d   = cycle_q;
        instr_d   = instr_q;
        code_d    = code_q;
        pc_d      = pc_q;
        last_pc_d = last_pc_q;

        if (running) begin
            cycle_d = cycle_q + 64'd1;
            instr_d = instr_inc;
            if (eff_valid[1]) begin
                last_pc_d = pc1;
            end else if (eff_valid[0]) begin
                last_pc_d = pc0;
            end

            if (trap0) begin
                code_d  = trap_code(io_trapArg);
                pc_d    = pc0;
                state_d = TRAPPED;
            end else if (trap1) begin
                code_d  = trap_code(io_trapArg);
                pc_d    = pc1;
                state_d = TRAPPED;
            end else if (limit_hit) begin
                code_d  = TRAP_LIMIT;
                pc_d    = last_pc_d;
                state_d = TRAPPED;
            end else if (wd_timeout) begin
                code_d  = TRAP_ABORT;
                pc_d    = last_pc_q;
                state_d = TRAPPED;
            end

            if (state_d == TRAPPED) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            valid_q   <= 1'b0;
            cycle_q   <= 64'd0;
            instr_q   <= 64'd0;
            code_q    <= TRAP_GOOD;
            pc_q      <= 64'd0;
            last_pc_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    assign io_coreid   = COREID;
    assign io_valid    = valid_q;
    assign io_cycleCnt = cycle_q;
    assign io_instrCnt = instr_q;
    assign io_code     = code_q;
    assign io_pc       = pc_q;

endmodule
